// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
//  Shared definitions for the UART command decoder: ASCII codes of the
//  recognised command bytes, the decoder FSM state type and the preset length.
//  No ports (package).
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_C_UP = 8'h43;
  localparam logic [7:0] ASCII_C_LO = 8'h63;
  localparam logic [7:0] ASCII_M_UP = 8'h4D;
  localparam logic [7:0] ASCII_M_LO = 8'h6D;
  localparam logic [7:0] ASCII_S_UP = 8'h53;
  localparam logic [7:0] ASCII_S_LO = 8'h73;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;

  // Number of decimal digits that make up one preset command.
  localparam int NUM_DIGITS = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    DIGITS = 1'b1
  } cmd_state_e;

endpackage : uart_cmd_pkg

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
//  Turns received ASCII bytes into 1-cycle control pulses for the 0..9999
//  counter. Commands: R/r run-stop toggle, C/c clear, M/m mode, S/s followed
//  by exactly four decimal digits to load a preset. CR, LF and space are
//  ignored between commands; anything else raises cmd_error.
//  All outputs are registered: a pulse appears the cycle after its byte.
//
//  Optional macro UART_CMD_TIMEOUT_EN: aborts a partial preset with
//  cmd_error after TIMEOUT_CYCLES idle cycles. Undefined: waits forever.
//
//  Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   rx_data[7:0]   in   received byte, qualified by rx_valid
//   rx_valid       in   one byte consumed per cycle while high
//   run_stop_pulse out  toggle run/stop
//   clear_pulse    out  clear counter
//   mode_pulse     out  change mode
//   preset_valid   out  preset_value has just been updated
//   preset_value   out  last decoded preset, held between presets
//   cmd_error      out  bad byte or timeout abort
// -----------------------------------------------------------------------------
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int VALUE_W        = 14,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               run_stop_pulse,
  output logic               clear_pulse,
  output logic               mode_pulse,
  output logic               preset_valid,
  output logic [VALUE_W-1:0] preset_value,
  output logic               cmd_error
);

  localparam int DIG_W = $clog2(NUM_DIGITS);

  cmd_state_e         state, state_d;
  logic [VALUE_W-1:0] acc, acc_d;
  logic [DIG_W-1:0]   dig_cnt, dig_cnt_d;

  logic               run_stop_d, clear_d, mode_d, preset_valid_d, cmd_error_d;
  logic [VALUE_W-1:0] preset_value_d;

  logic               is_digit;
  logic               last_digit;
  logic [VALUE_W-1:0] acc_nxt;
  logic               tmo_expire;

  assign is_digit   = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
  assign last_digit = (dig_cnt == DIG_W'(NUM_DIGITS - 1));
  // acc*10 + digit; at most 999*10+9 = 9999, so VALUE_W never overflows.
  assign acc_nxt    = (acc << 3) + (acc << 1) + VALUE_W'(rx_data[3:0]);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt;

  // An arriving byte takes priority over expiry on the same cycle.
  assign tmo_expire = (state == DIGITS) && !rx_valid &&
                      (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state != DIGITS || rx_valid || tmo_expire) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign tmo_expire         = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register: FSM, accumulator and all registered outputs.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      dig_cnt        <= '0;
      run_stop_pulse <= 1'b0;
      clear_pulse    <= 1'b0;
      mode_pulse     <= 1'b0;
      preset_valid   <= 1'b0;
      preset_value   <= '0;
      cmd_error      <= 1'b0;
    end else begin
      state          <= state_d;
      acc            <= acc_d;
      dig_cnt        <= dig_cnt_d;
      run_stop_pulse <= run_stop_d;
      clear_pulse    <= clear_d;
      mode_pulse     <= mode_d;
      preset_valid   <= preset_valid_d;
      preset_value   <= preset_value_d;
      cmd_error      <= cmd_error_d;
    end
  end

  // Next-state logic: FSM transitions and accumulator/digit bookkeeping.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    acc_d     = acc;
    dig_cnt_d = dig_cnt;
    unique case (state)
      IDLE: begin
        if (rx_valid && (rx_data == ASCII_S_UP || rx_data == ASCII_S_LO)) begin
          state_d   = DIGITS;
          acc_d     = '0;
          dig_cnt_d = '0;
        end
      end
      DIGITS: begin
        if (rx_valid) begin
          if (is_digit && !last_digit) begin
            acc_d     = acc_nxt;
            dig_cnt_d = dig_cnt + 1'b1;
          end else begin
            // Completed preset or bad byte: the byte is consumed here and
            // never reinterpreted as a command.
            state_d   = IDLE;
            acc_d     = '0;
            dig_cnt_d = '0;
          end
        end else if (tmo_expire) begin
          state_d   = IDLE;
          acc_d     = '0;
          dig_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered pulses and preset.
  always_comb begin
    run_stop_d     = 1'b0;
    clear_d        = 1'b0;
    mode_d         = 1'b0;
    preset_valid_d = 1'b0;
    cmd_error_d    = 1'b0;
    preset_value_d = preset_value;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          unique case (rx_data)
            ASCII_R_UP, ASCII_R_LO: run_stop_d = 1'b1;
            ASCII_C_UP, ASCII_C_LO: clear_d    = 1'b1;
            ASCII_M_UP, ASCII_M_LO: mode_d     = 1'b1;
            ASCII_S_UP, ASCII_S_LO,
            ASCII_CR, ASCII_LF, ASCII_SP: ;
            default:                cmd_error_d = 1'b1;
          endcase
        end
      end
      DIGITS: begin
        if (rx_valid) begin
          if (!is_digit) begin
            cmd_error_d = 1'b1;
          end else if (last_digit) begin
            preset_valid_d = 1'b1;
            preset_value_d = acc_nxt;
          end
        end else if (tmo_expire) begin
          cmd_error_d = 1'b1;
        end
      end
      default: cmd_error_d = 1'b0;
    endcase
  end

endmodule : uart_cmd_decoder

// File: tb/tb_uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_decoder
//  Directed self-checking bench for uart_cmd_decoder. Each step drives one
//  cycle of rx_valid/rx_data, waits for the clock edge and compares the five
//  pulse outputs and preset_value against hand-computed values.
//  Built with UART_CMD_TIMEOUT_EN it also exercises the timeout abort.
// -----------------------------------------------------------------------------
module tb_uart_cmd_decoder;

  localparam int VALUE_W = 14;

  // Flag order: {run_stop, clear, mode, preset_valid, cmd_error}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_RUN  = 5'b10000;
  localparam logic [4:0] F_CLR  = 5'b01000;
  localparam logic [4:0] F_MODE = 5'b00100;
  localparam logic [4:0] F_PV   = 5'b00010;
  localparam logic [4:0] F_ERR  = 5'b00001;

  logic               clk;
  logic               rst;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               run_stop_pulse;
  logic               clear_pulse;
  logic               mode_pulse;
  logic               preset_valid;
  logic [VALUE_W-1:0] preset_value;
  logic               cmd_error;

  int total  = 0;
  int passed = 0;

  uart_cmd_decoder #(
    .VALUE_W        (VALUE_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .run_stop_pulse (run_stop_pulse),
    .clear_pulse    (clear_pulse),
    .mode_pulse     (mode_pulse),
    .preset_valid   (preset_valid),
    .preset_value   (preset_value),
    .cmd_error      (cmd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag, input logic [4:0] exp_flags,
                               input logic [VALUE_W-1:0] exp_val);
    check({tag, " flags"},
          32'({run_stop_pulse, clear_pulse, mode_pulse, preset_valid, cmd_error}),
          32'(exp_flags));
    check({tag, " value"}, 32'(preset_value), 32'(exp_val));
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic [4:0] exp_flags, input logic [VALUE_W-1:0] exp_val);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    check_outputs(tag, exp_flags, exp_val);
  endtask

  task automatic idle(input string tag, input logic [VALUE_W-1:0] exp_val);
    step(tag, 1'b0, 8'h00, F_NONE, exp_val);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", F_NONE, 14'd0);
    rst = 1'b0;

    // 1: reset in the middle of a preset discards it
    step("t1 S",  1'b1, "S", F_NONE, 14'd0);
    step("t1 1",  1'b1, "1", F_NONE, 14'd0);
    step("t1 2",  1'b1, "2", F_NONE, 14'd0);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_outputs("t1 async rst", F_NONE, 14'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("t1 S2",   1'b1, "S", F_NONE, 14'd0);
    step("t1 0a",   1'b1, "0", F_NONE, 14'd0);
    step("t1 0b",   1'b1, "0", F_NONE, 14'd0);
    step("t1 0c",   1'b1, "0", F_NONE, 14'd0);
    step("t1 1",    1'b1, "1", F_PV,   14'd1);
    idle("t1 hold", 14'd1);

    // 2: single-byte commands, each a 1-cycle pulse
    step("t2 r",   1'b1, "r", F_RUN,  14'd1);
    idle("t2 r-",  14'd1);
    step("t2 C",   1'b1, "C", F_CLR,  14'd1);
    idle("t2 C-",  14'd1);
    step("t2 m",   1'b1, "m", F_MODE, 14'd1);
    idle("t2 m-",  14'd1);
    // back-to-back commands
    step("t2 R",   1'b1, "R", F_RUN,  14'd1);
    step("t2 M",   1'b1, "M", F_MODE, 14'd1);
    idle("t2 M-",  14'd1);
    // rx_data ignored without rx_valid
    step("t2 novalid", 1'b0, "R", F_NONE, 14'd1);

    // 3: max preset back-to-back, then another
    step("t3 S",  1'b1, "S", F_NONE, 14'd1);
    step("t3 9a", 1'b1, "9", F_NONE, 14'd1);
    step("t3 9b", 1'b1, "9", F_NONE, 14'd1);
    step("t3 9c", 1'b1, "9", F_NONE, 14'd1);
    step("t3 9d", 1'b1, "9", F_PV,   14'd9999);
    idle("t3 hold", 14'd9999);
    step("t3 s",  1'b1, "s", F_NONE, 14'd9999);
    step("t3 0",  1'b1, "0", F_NONE, 14'd9999);
    step("t3 4",  1'b1, "4", F_NONE, 14'd9999);
    step("t3 2",  1'b1, "2", F_NONE, 14'd9999);
    step("t3 0b", 1'b1, "0", F_PV,   14'd420);
    idle("t3 hold2", 14'd420);

    // 4: bad byte inside a preset keeps the old value
    step("t4 S",  1'b1, "S", F_NONE, 14'd420);
    step("t4 1",  1'b1, "1", F_NONE, 14'd420);
    step("t4 x",  1'b1, "x", F_ERR,  14'd420);
    idle("t4 x-", 14'd420);
    step("t4 c",  1'b1, "c", F_CLR,  14'd420);
    idle("t4 c-", 14'd420);
    // the offending byte is not reinterpreted as a command
    step("t4 S2", 1'b1, "S", F_NONE, 14'd420);
    step("t4 R",  1'b1, "R", F_ERR,  14'd420);
    idle("t4 R-", 14'd420);
    // CR inside a preset is an error too
    step("t4 S3", 1'b1, "S", F_NONE, 14'd420);
    step("t4 CR", 1'b1, 8'h0D, F_ERR, 14'd420);

    // 5: unknown byte and ignored whitespace in IDLE
    step("t5 Z",  1'b1, "Z",   F_ERR,  14'd420);
    idle("t5 Z-", 14'd420);
    step("t5 CR", 1'b1, 8'h0D, F_NONE, 14'd420);
    step("t5 LF", 1'b1, 8'h0A, F_NONE, 14'd420);
    step("t5 SP", 1'b1, 8'h20, F_NONE, 14'd420);
    step("t5 R",  1'b1, "R",   F_RUN,  14'd420);

`ifdef UART_CMD_TIMEOUT_EN
    // 6: 16 idle cycles abort a partial preset
    step("t6 S", 1'b1, "S", F_NONE, 14'd420);
    step("t6 5", 1'b1, "5", F_NONE, 14'd420);
    for (int i = 0; i < 15; i++) idle("t6 wait", 14'd420);
    step("t6 expire", 1'b0, 8'h00, F_ERR, 14'd420);
    step("t6 R",      1'b1, "R",   F_RUN, 14'd420);
    // byte on the expiry cycle wins and restarts the count
    step("t6 S2", 1'b1, "S", F_NONE, 14'd420);
    step("t6 5b", 1'b1, "5", F_NONE, 14'd420);
    for (int i = 0; i < 15; i++) idle("t6 wait2", 14'd420);
    step("t6 7", 1'b1, "7", F_NONE, 14'd420);
    for (int i = 0; i < 15; i++) idle("t6 wait3", 14'd420);
    step("t6 8", 1'b1, "8", F_NONE, 14'd420);
    step("t6 9", 1'b1, "9", F_PV,   14'd5789);
    idle("t6 hold", 14'd5789);
`else
    // 6: without the timeout a partial preset waits indefinitely
    step("t6 S", 1'b1, "S", F_NONE, 14'd420);
    step("t6 5", 1'b1, "5", F_NONE, 14'd420);
    for (int i = 0; i < 40; i++) idle("t6 wait", 14'd420);
    step("t6 1", 1'b1, "1", F_NONE, 14'd420);
    step("t6 2", 1'b1, "2", F_NONE, 14'd420);
    step("t6 3", 1'b1, "3", F_PV,   14'd5123);
    idle("t6 hold", 14'd5123);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_uart_cmd_decoder
